// File: rtl/hub75_scan_ctrl_if.sv
// Pixel-memory read port and HUB75 panel pins of the scan controller.
// master: the scan controller (drives addresses and panel pins).
// slave:  the pixel memory / panel side.
interface hub75_scan_ctrl_if;
  logic [13:0] rd_addr;
  logic [2:0]  rd_bit_plane;
  logic        r0, g0, b0, r1, g1, b1;
  logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
  logic        hub_clk;
  logic        hub_lat;
  logic        hub_oe_n;
  logic [4:0]  hub_addr;

  modport master (
    output rd_addr, rd_bit_plane,
    input  r0, g0, b0, r1, g1, b1,
    output hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
    output hub_clk, hub_lat, hub_oe_n, hub_addr
  );

  modport slave (
    input  rd_addr, rd_bit_plane,
    output r0, g0, b0, r1, g1, b1,
    input  hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1,
    input  hub_clk, hub_lat, hub_oe_n, hub_addr
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: 32 row pairs, bit planes 2..7, binary-weighted
// display time per plane. All panel pins are registered.
// Build option HUB75_DEAD_TIME_EN inserts a blanking gap of DEAD_CYCLES
// after every latch; without it the latch goes straight to display.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | panel blanked, waiting for enable
// SHIFT   | clock one plane of one row pair into the panel, 2 clk/column
// LATCH   | one-cycle latch strobe, row select updated
// DEAD    | blanking after the latch (HUB75_DEAD_TIME_EN builds only)
// DISPLAY | panel lit for BASE_CYCLES << (plane-2) cycles
module hub75_scan_ctrl #(
  parameter int PANELS      = 1,
  parameter int BASE_CYCLES = 8,
  parameter int DEAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic              frame_done,
  hub75_scan_ctrl_if.master bus
);

  localparam int          COLS     = 64 * PANELS;
  localparam logic [8:0]  LAST_COL = 9'(COLS - 1);
  localparam logic [12:0] BASE_LEN = 13'(BASE_CYCLES);
`ifdef HUB75_DEAD_TIME_EN
  localparam logic [12:0] DEAD_LOAD = 13'(DEAD_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DEAD, DISPLAY} state_t;
`else
  // Dead-time length has no effect when the blanking gap is not built.
  localparam int unused_dead_cycles = DEAD_CYCLES;
  typedef enum logic [2:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;
`endif

  state_t      state, nxt_state;
  logic [8:0]  col, nxt_col;
  logic        phase, nxt_phase;
  logic [4:0]  row, nxt_row;
  logic [2:0]  plane, nxt_plane;     // plane index 0..5 = bit plane 2..7
  logic [12:0] timer, nxt_timer;     // down-counter, terminal count at 0
  logic        nxt_done;
  logic [12:0] disp_len;
  logic [4:0]  up_row;
  logic [2:0]  up_plane;

  assign disp_len = BASE_LEN << plane;

  // State and counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      col   <= '0;
      phase <= 1'b0;
      row   <= '0;
      plane <= '0;
      timer <= '0;
    end else begin
      state <= nxt_state;
      col   <= nxt_col;
      phase <= nxt_phase;
      row   <= nxt_row;
      plane <= nxt_plane;
      timer <= nxt_timer;
    end
  end

  // Next-state and counter update
  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_phase = phase;
    nxt_row   = row;
    nxt_plane = plane;
    nxt_timer = timer;
    nxt_done  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          nxt_state = SHIFT;
          nxt_col   = '0;
          nxt_phase = 1'b0;
          nxt_row   = '0;
          nxt_plane = '0;
        end
      end
      SHIFT: begin
        nxt_phase = ~phase;
        if (phase) begin
          if (col == LAST_COL) begin
            nxt_col   = '0;
            nxt_state = LATCH;
          end else begin
            nxt_col = col + 9'd1;
          end
        end
      end
      LATCH: begin
`ifdef HUB75_DEAD_TIME_EN
        nxt_state = DEAD;
        nxt_timer = DEAD_LOAD;
`else
        nxt_state = DISPLAY;
        nxt_timer = disp_len - 13'd1;
`endif
      end
`ifdef HUB75_DEAD_TIME_EN
      DEAD: begin
        if (timer == 13'd0) begin
          nxt_state = DISPLAY;
          nxt_timer = disp_len - 13'd1;
        end else begin
          nxt_timer = timer - 13'd1;
        end
      end
`endif
      DISPLAY: begin
        if (timer == 13'd0) begin
          nxt_state = SHIFT;
          if (plane != 3'd5) begin
            nxt_plane = plane + 3'd1;
          end else begin
            nxt_plane = '0;
            if (row != 5'd31) begin
              nxt_row = row + 5'd1;
            end else begin
              // frame end: enable is only looked at here
              nxt_row  = '0;
              nxt_done = 1'b1;
              if (!enable) nxt_state = IDLE;
            end
          end
        end else begin
          nxt_timer = timer - 13'd1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Row/plane that the next SHIFT will scan, used to prefetch column 0
  always_comb begin
    up_row   = nxt_row;
    up_plane = nxt_plane + 3'd1;
    if (nxt_plane == 3'd5) begin
      up_plane = '0;
      up_row   = nxt_row + 5'd1;
    end
  end

  // Registered panel pins, memory address and frame pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.hub_clk      <= 1'b0;
      bus.hub_lat      <= 1'b0;
      bus.hub_oe_n     <= 1'b1;
      bus.hub_addr     <= '0;
      bus.hub_r0       <= 1'b0;
      bus.hub_g0       <= 1'b0;
      bus.hub_b0       <= 1'b0;
      bus.hub_r1       <= 1'b0;
      bus.hub_g1       <= 1'b0;
      bus.hub_b1       <= 1'b0;
      bus.rd_addr      <= '0;
      bus.rd_bit_plane <= 3'd2;
      frame_done       <= 1'b0;
    end else begin
      bus.hub_clk  <= (nxt_state == SHIFT) && nxt_phase;
      bus.hub_lat  <= (nxt_state == LATCH);
      bus.hub_oe_n <= (nxt_state != DISPLAY);
      frame_done   <= nxt_done;
      if (nxt_state == LATCH) bus.hub_addr <= nxt_row;
      // column data changes only on the edge that starts hub_clk low phase
      if ((nxt_state == SHIFT) && !nxt_phase) begin
        bus.hub_r0 <= bus.r0;
        bus.hub_g0 <= bus.g0;
        bus.hub_b0 <= bus.b0;
        bus.hub_r1 <= bus.r1;
        bus.hub_g1 <= bus.g1;
        bus.hub_b1 <= bus.b1;
      end
      // address runs one column ahead so memory data is ready at load time
      if (nxt_state == SHIFT) begin
        bus.rd_addr      <= {nxt_row, (nxt_col == LAST_COL) ? 9'd0 : nxt_col + 9'd1};
        bus.rd_bit_plane <= nxt_plane + 3'd2;
      end else if (nxt_state == IDLE) begin
        bus.rd_addr      <= '0;
        bus.rd_bit_plane <= 3'd2;
      end else begin
        bus.rd_addr      <= {up_row, 9'd0};
        bus.rd_bit_plane <= up_plane + 3'd2;
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl (PANELS=1, BASE_CYCLES=8, DEAD_CYCLES=4).
// Pixel memory holds random colour bits per (plane,row,col); r0 carries
// column parity and b1 its inverse. Expected scan timing is computed from
// the row/plane schedule and plane weights.
module tb_hub75_scan_ctrl;
  localparam int PANELS   = 1;
  localparam int BASE     = 8;
  localparam int DEAD_CYC = 4;
  localparam int COLS     = 64 * PANELS;
`ifdef HUB75_DEAD_TIME_EN
  localparam int DEAD_EXP = DEAD_CYC;
`else
  localparam int DEAD_EXP = 0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic frame_done;

  hub75_scan_ctrl_if bus();

  hub75_scan_ctrl #(
    .PANELS(PANELS),
    .BASE_CYCLES(BASE),
    .DEAD_CYCLES(DEAD_CYC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .frame_done(frame_done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int plane_bad = 0;
  bit hung = 0;
  int done_q[$];

  logic [3:0] rnd_tab [0:5][0:31][0:63];
  logic [5:0] mem_q = '0;

  function automatic logic [5:0] pix_of(input int row, input int pl, input int c);
    logic [3:0] t;
    if (pl < 0 || pl > 5 || c < 0 || c >= COLS || row < 0 || row > 31) return 6'd0;
    t = rnd_tab[pl][row][c];
    return {c[0], t[3], t[2], t[1], t[0], ~c[0]};
  endfunction

  // memory: read data follows the address within the following clock
  always @(negedge clk)
    mem_q <= pix_of(int'(bus.rd_addr[13:9]), int'(bus.rd_bit_plane) - 2, int'(bus.rd_addr[8:0]));
  assign bus.r0 = mem_q[5];
  assign bus.g0 = mem_q[4];
  assign bus.b0 = mem_q[3];
  assign bus.r1 = mem_q[2];
  assign bus.g1 = mem_q[1];
  assign bus.b1 = mem_q[0];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_q.push_back(cyc);
    if (cyc > 0 && bus.rd_bit_plane < 3'd2) plane_bad++;
  end

  function automatic logic [5:0] hub_pix();
    return {bus.hub_r0, bus.hub_g0, bus.hub_b0, bus.hub_r1, bus.hub_g1, bus.hub_b1};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first SHIFT cycle of (row, plane index pl). Returns on the
  // first cycle after DISPLAY, or after cut_disp display cycles if cut_disp>=0.
  task automatic run_segment(input int row, input int pl, input int cut_disp);
    int n, rises, oe_bad, dd, dis;
    logic prev_clk;
    if (hung) return;
    check_val("shift_plane", bus.rd_bit_plane, pl + 2);
    n = 0; rises = 0; oe_bad = 0; prev_clk = 1'b0;
    while (bus.hub_lat !== 1'b1 && n < 4 * COLS + 8) begin
      if (bus.hub_oe_n !== 1'b1) oe_bad++;
      if (bus.hub_clk === 1'b1 && prev_clk !== 1'b1) begin
        check_val("pix", hub_pix(), pix_of(row, pl, rises));
        rises++;
      end
      prev_clk = bus.hub_clk;
      n++;
      step();
    end
    check_val("shift_len", n, 2 * COLS);
    check_val("clk_rises", rises, COLS);
    check_val("shift_oe", oe_bad, 0);
    if (bus.hub_lat !== 1'b1) begin
      hung = 1;
      return;
    end
    check_val("lat_addr", bus.hub_addr, row);
    check_val("lat_clk", bus.hub_clk, 0);
    check_val("lat_oe", bus.hub_oe_n, 1);
    step();
    check_val("lat_width", bus.hub_lat, 0);
    dd = 0;
    while (bus.hub_oe_n === 1'b1 && dd < 64) begin
      dd++;
      step();
    end
    check_val("dead_len", dd, DEAD_EXP);
    if (dd >= 64) begin
      hung = 1;
      return;
    end
    dis = 0;
    while (bus.hub_oe_n === 1'b0 && dis < 10000) begin
      if (cut_disp >= 0 && dis == cut_disp) return;
      dis++;
      step();
    end
    check_val("disp_len", dis, BASE << pl);
    if (dis >= 10000) hung = 1;
  endtask

  initial begin
    int drop_row, cut, idle_n, bad, start_cyc, fe_cyc, frame_len;
    for (int p = 0; p < 6; p++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 64; c++)
          rnd_tab[p][r][c] = 4'($urandom);
    frame_len = 0;
    for (int p = 0; p < 6; p++) frame_len += 2 * COLS + 1 + DEAD_EXP + (BASE << p);
    frame_len *= 32;
    drop_row = $urandom_range(8, 12);
    cut = $urandom_range(1, (BASE << 2) - 1);

    // reset held with enable high
    resetn = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_oe", bus.hub_oe_n, 1);
      check_val("rst_clk", bus.hub_clk, 0);
      check_val("rst_lat", bus.hub_lat, 0);
      check_val("rst_plane", bus.rd_bit_plane, 2);
      check_val("rst_done", frame_done, 0);
      check_val("rst_addr", bus.hub_addr, 0);
      check_val("rst_rdaddr", bus.rd_addr, 0);
      check_val("rst_pix", hub_pix(), 0);
    end
    resetn = 1'b1;
    step();
    start_cyc = cyc;

    // full frame, enable dropped mid-frame
    for (int r = 0; r < 32; r++)
      for (int p = 0; p < 6; p++) begin
        if (r == drop_row && p == 0) enable = 1'b0;
        run_segment(r, p, -1);
      end
    fe_cyc = cyc;
    check_val("frame_done", frame_done, 1);
    check_val("frame_len", cyc - start_cyc, frame_len);
    idle_n = $urandom_range(30, 120);
    bad = 0;
    for (int i = 0; i < idle_n; i++) begin
      step();
      if (bus.hub_oe_n !== 1'b1 || bus.hub_clk !== 1'b0 || bus.hub_lat !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check_val("idle_hold", bad, 0);
    check_val("done_count", done_q.size(), 1);
    if (done_q.size() > 0) check_val("done_cycle", done_q[0], fe_cyc);

    // restart, then reset pulse during row 5 plane 4 display
    enable = 1'b1;
    step();
    for (int r = 0; r < 5; r++)
      for (int p = 0; p < 6; p++) run_segment(r, p, -1);
    run_segment(5, 0, -1);
    run_segment(5, 1, -1);
    run_segment(5, 2, cut);
    check_val("pre_rst_oe", bus.hub_oe_n, 0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_val("mid_rst_oe", bus.hub_oe_n, 1);
    check_val("mid_rst_addr", bus.hub_addr, 0);
    check_val("mid_rst_clk", bus.hub_clk, 0);
    check_val("mid_rst_plane", bus.rd_bit_plane, 2);
    check_val("mid_rst_rdaddr", bus.rd_addr, 0);
    step();
    run_segment(0, 0, -1);
    run_segment(0, 1, -1);

    check_val("done_total", done_q.size(), 1);
    check_val("plane_range", plane_bad, 0);
    check_val("no_hang", hung, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter PANELS, default 1, number of 64-column panels chained horizontally (1..8).
REQ-002 Parameter BASE_CYCLES, default 8, display time in clk cycles of the least-significant plane (plane 2), range 1..255.
REQ-003 Parameter DEAD_CYCLES, default 4, blanking cycles after each latch (used only with HUB75_DEAD_TIME_EN).
REQ-004 Clocking: one clock; reset is synchronous and active-low.
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- enable  input  1  scanning permitted; sampled only at frame start.
- rd_addr  output  14  pixel-memory read address {row[4:0], col[8:0]}.
- rd_bit_plane  output  3  bit plane selected on the pixel memory, 2..7.
- r0, g0, b0, r1, g1, b1  input  1 each  plane bits for row n and row n+32, valid 1 clk after rd_addr/rd_bit_plane change.
- hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1  output  1 each  registered panel colour data.
- hub_clk  output  1  panel shift clock.
- hub_lat  output  1  panel latch strobe, active high.
- hub_oe_n  output  1  panel output enable, active low.
- hub_addr  output  5  panel row select A..E.
- frame_done  output  1  one-cycle pulse at end of each full frame.

Function
REQ-005 States: IDLE, SHIFT, LATCH, DEAD (macro only), DISPLAY; scan order row 0..31 outer, plane 2..7 inner.
REQ-006 IDLE: hub_oe_n=1, hub_clk=0, hub_lat=0; go to SHIFT (row 0, plane 2) when enable=1, else stay.
REQ-007 SHIFT: 2 clk per column, COLS=64*PANELS columns, columns 0..COLS-1 in order; shift length 2*COLS cycles.
REQ-008 Column phase 0: hub_clk=0, hub_* data update to column c; phase 1: hub_clk=1; data stable across the rising hub_clk edge.
REQ-009 rd_addr for column c is presented at least 1 clk before the phase-0 edge that loads hub_* for column c (memory latency 1 clk).
REQ-010 hub_oe_n=1 throughout SHIFT, LATCH and DEAD.
REQ-011 LATCH: exactly 1 clk, hub_lat=1, hub_clk=0, hub_addr updated to current row in this same cycle.
REQ-012 DISPLAY: hub_oe_n=0 for exactly BASE_CYCLES << (plane-2) cycles (plane 7 = 32*BASE_CYCLES); counter width sized for 32*255.
REQ-013 After DISPLAY: plane<7 -> SHIFT plane+1 same row; plane 7 and row<31 -> SHIFT row+1 plane 2; plane 7 row 31 -> frame end.
REQ-014 Frame end: frame_done=1 for one clk; then SHIFT row 0 plane 2 if enable=1, else IDLE.
REQ-015 enable deasserted mid-frame: current frame completes unchanged, then IDLE.
REQ-016 rd_bit_plane equals current plane during SHIFT; never outside 2..7.
REQ-017 Column counter wraps at COLS-1; row counter wraps 31->0 only at frame end.

Reset
REQ-018 While resetn=0 at a clk edge: state IDLE, hub_oe_n=1, hub_clk=0, hub_lat=0, hub_addr=0, hub_* data=0, rd_addr=0, rd_bit_plane=2, frame_done=0, all counters 0.
REQ-019 Reset mid-operation aborts the frame immediately; first post-reset SHIFT starts at row 0, plane 2, column 0.

Configuration
REQ-020 Macro HUB75_DEAD_TIME_EN defined: DEAD state of DEAD_CYCLES clk, hub_oe_n=1, between LATCH and DISPLAY; undefined: LATCH goes directly to DISPLAY, DEAD state absent.

Verification
REQ-021 Reset: resetn=0 3 clk with enable=1 -> hub_oe_n=1, hub_clk=0, rd_bit_plane=2, frame_done=0 throughout.
REQ-022 PANELS=1, BASE_CYCLES=8, macro off, enable=1 -> 128 clk SHIFT (64 hub_clk rises), 1 clk hub_lat, hub_oe_n low 8 clk for plane 2 and 256 clk for plane 7; frame_done every 40896 clk.
REQ-023 Same config, macro on, DEAD_CYCLES=4 -> 4 clk hub_oe_n=1 after each hub_lat; frame_done every 41664 clk.
REQ-024 Memory model returning col[0] on r0, ~col[0] on b1 with 1 clk latency -> at each hub_clk rise hub_r0 equals column parity, hub_b1 its inverse, 64 columns, no offset.
REQ-025 enable dropped at row 10 -> frame completes to row 31 plane 7, frame_done pulses, then IDLE with hub_oe_n=1 indefinitely.
REQ-026 resetn pulsed low 1 clk during row 5 plane 4 DISPLAY -> hub_oe_n=1 next clk, restart at row 0 plane 2 column 0, hub_addr=0.
